// File: rtl/fifo_uart_pkg.sv
// Shared types and constants for the FIFO-draining UART transmitter.
// Contents: frame-state encoding, data width, and a helper that sizes the bit-period counter.
package fifo_uart_pkg;

    localparam int unsigned DATA_BITS = 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_e;

    // Counter width for a 0..clks-1 count; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned clks);
        return (clks > 2) ? $clog2(clks) : 1;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period timer: counts clk cycles within one serial bit.
// Ports:
//   clk, rst_n   - clock, async active-low reset
//   restart_i    - hold the count at zero (asserted while the line is idle)
//   bit_end_c_o  - combinational, high on the last cycle of each bit period
module uart_baud_tick
    import fifo_uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic restart_i,
    output logic bit_end_c_o
);

    localparam int unsigned    CNT_W    = cnt_width(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign bit_end_c_o = (cnt_q == CNT_LAST);

    // Wrap at the end of each bit so consecutive bits need no reload.
    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (restart_i || bit_end_c_o) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/fifo_uart_tx.sv
// Drains a first-word-fall-through FIFO and serializes each byte as a UART frame:
// start bit, 8 data bits LSB first, optional even parity, one stop bit.
// Ports:
//   clk, rst_n    - clock, async active-low reset
//   ena           - allows new frames to start (a running frame always completes)
//   fifo_empty    - FIFO empty flag
//   fifo_rd_data  - FIFO head byte, valid while fifo_empty is low
//   fifo_rd_en    - one-cycle pop strobe (combinational from registered state)
//   tx            - serial line, idle high
//   busy          - high while a frame is in progress
//   frame_done    - one-cycle pulse on the last cycle of the stop bit
module fifo_uart_tx
    import fifo_uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 4,
    parameter bit          PARITY_EN    = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ena,
    input  logic                 fifo_empty,
    input  logic [DATA_BITS-1:0] fifo_rd_data,
    output logic                 fifo_rd_en,
    output logic                 tx,
    output logic                 busy,
    output logic                 frame_done
);

    localparam int unsigned BIT_CNT_W = $clog2(DATA_BITS);
    localparam logic [BIT_CNT_W-1:0] BIT_LAST = BIT_CNT_W'(DATA_BITS - 1);

    uart_state_e            state_q;
    logic [DATA_BITS-1:0]   shift_q;
    logic [BIT_CNT_W-1:0]   bit_cnt_q;
    logic                   parity_q;
    logic                   tx_q;
    logic                   busy_q;
    logic                   bit_end;
    logic                   pop;

    uart_baud_tick #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_tick (
        .clk         (clk),
        .rst_n       (rst_n),
        .restart_i   (state_q == IDLE),
        .bit_end_c_o (bit_end)
    );

    // Pop from idle, or on the final stop cycle for gap-free back-to-back frames.
    // rst_n gating keeps the strobe low while reset is held with the FIFO non-empty.
    assign pop = rst_n && ena && !fifo_empty &&
                 ((state_q == IDLE) || ((state_q == STOP) && bit_end));

    assign fifo_rd_en = pop;
    assign frame_done = (state_q == STOP) && bit_end;
    assign tx         = tx_q;
    assign busy       = busy_q;

    // Frame sequencer; tx_q is loaded with the level of the bit being entered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            parity_q  <= 1'b0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
        end else if (pop) begin
            shift_q   <= fifo_rd_data;
            parity_q  <= ^fifo_rd_data;
            bit_cnt_q <= '0;
            state_q   <= START;
            tx_q      <= 1'b0;
            busy_q    <= 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    tx_q   <= 1'b1;
                    busy_q <= 1'b0;
                end
                START: begin
                    if (bit_end) begin
                        state_q <= DATA;
                        tx_q    <= shift_q[0];
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        shift_q <= shift_q >> 1;
                        if (bit_cnt_q == BIT_LAST) begin
                            bit_cnt_q <= '0;
                            if (PARITY_EN) begin
                                state_q <= PARITY;
                                tx_q    <= parity_q;
                            end else begin
                                state_q <= STOP;
                                tx_q    <= 1'b1;
                            end
                        end else begin
                            bit_cnt_q <= bit_cnt_q + BIT_CNT_W'(1);
                            tx_q      <= shift_q[1];
                        end
                    end
                end
                PARITY: begin
                    if (bit_end) begin
                        state_q <= STOP;
                        tx_q    <= 1'b1;
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        state_q <= IDLE;
                        tx_q    <= 1'b1;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    tx_q    <= 1'b1;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: dut0 (no parity) is shadowed every cycle by a frame-level
// reference model; dut1 (even parity) is exercised through the vector table.
module tb_fifo_uart_tx;

    localparam int unsigned CPB = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic       ena0, empty0, rd_en0, tx0, busy0, done0;
    logic [7:0] data0;
    logic       ena1, empty1, rd_en1, tx1, busy1, done1;
    logic [7:0] data1;

    logic [7:0] q0[$];
    logic [7:0] q1[$];
    logic       pend0 = 1'b0;
    logic       pend1 = 1'b0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fifo_uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .ena(ena0), .fifo_empty(empty0),
        .fifo_rd_data(data0), .fifo_rd_en(rd_en0), .tx(tx0),
        .busy(busy0), .frame_done(done0)
    );

    fifo_uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n), .ena(ena1), .fifo_empty(empty1),
        .fifo_rd_data(data1), .fifo_rd_en(rd_en1), .tx(tx1),
        .busy(busy1), .frame_done(done1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, req);
        end
    endtask

    // FIFO heads; garbage on the data bus while empty.
    function automatic void refresh();
        empty0 = (q0.size() == 0);
        data0  = empty0 ? 8'($urandom) : q0[0];
        empty1 = (q1.size() == 0);
        data1  = empty1 ? 8'($urandom) : q1[0];
    endfunction

    // FIFO model: a strobe seen mid-cycle pops at the following edge.
    always @(negedge clk) begin
        pend0 = rd_en0;
        pend1 = rd_en1;
    end

    always @(posedge clk) begin
        #1;
        if (pend0 && q0.size() != 0) void'(q0.pop_front());
        if (pend1 && q1.size() != 0) void'(q1.pop_front());
        pend0 = 1'b0;
        pend1 = 1'b0;
        refresh();
    end

    // Reference model for dut0: expected per-cycle line level and done flag.
    typedef struct packed {
        logic tx;
        logic done;
    } exp_t;

    exp_t exp_q[$];

    function automatic void append_frame(input logic [7:0] b);
        logic [9:0] bits;
        exp_t       e;
        bits = {1'b1, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            for (int k = 0; k < int'(CPB); k++) begin
                e.tx   = bits[i];
                e.done = (i == 9) && (k == int'(CPB) - 1);
                exp_q.push_back(e);
            end
        end
    endfunction

    always @(negedge clk) begin : model_chk
        logic e_tx, e_busy, e_done, e_pop;
        if (!rst_n) begin
            exp_q.delete();
            e_tx = 1'b1; e_busy = 1'b0; e_done = 1'b0; e_pop = 1'b0;
        end else begin
            e_busy = (exp_q.size() != 0);
            e_tx   = e_busy ? exp_q[0].tx : 1'b1;
            e_done = e_busy ? exp_q[0].done : 1'b0;
            e_pop  = (exp_q.size() <= 1) && ena0 && (q0.size() != 0);
        end
        chk("model_tx", 32'(tx0), 32'(e_tx));
        chk("model_busy", 32'(busy0), 32'(e_busy));
        chk("model_done", 32'(done0), 32'(e_done));
        chk("model_pop", 32'(rd_en0), 32'(e_pop));
        if (rst_n) begin
            if (exp_q.size() != 0) void'(exp_q.pop_front());
            if (e_pop) append_frame(q0[0]);
        end
    end

    // Directed frame vectors with hand-derived expectations.
    typedef struct {
        logic       par;
        logic [7:0] data;
        logic       exp_par;
        int         len;
    } vec_t;

    vec_t vecs[6];

    task automatic wait_idle(input int budget);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (!busy0 && !busy1 && q0.size() == 0 && q1.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        chk("idle_timeout", 32'(ok), 32'd1);
    endtask

    task automatic wait_pop0(input int budget, output bit got);
        got = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (rd_en0) begin
                got = 1'b1;
                break;
            end
        end
    endtask

    task automatic run_vec(input vec_t v);
        bit          got;
        logic [10:0] frame;
        int          done_cyc, pops, nb;
        logic        txv;
        @(posedge clk); #1;
        if (v.par) q1.push_back(v.data); else q0.push_back(v.data);
        refresh();
        got = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if ((v.par ? rd_en1 : rd_en0) == 1'b1) begin
                got = 1'b1;
                break;
            end
        end
        chk("vec_pop", 32'(got), 32'd1);
        if (!got) return;
        frame = '0; done_cyc = -1; pops = 0; nb = v.len / int'(CPB);
        for (int c = 1; c <= v.len + 1; c++) begin
            @(negedge clk);
            txv = v.par ? tx1 : tx0;
            if (((c - 1) % int'(CPB)) == 1 && (c - 1) / int'(CPB) < 11)
                frame[(c - 1) / int'(CPB)] = txv;
            if ((v.par ? done1 : done0) && done_cyc < 0) done_cyc = c;
            if (v.par ? rd_en1 : rd_en0) pops++;
            if (c == v.len + 1) chk("vec_busy_after", 32'(v.par ? busy1 : busy0), 32'd0);
        end
        chk("vec_start", 32'(frame[0]), 32'd0);
        chk("vec_data", 32'(frame[8:1]), 32'(v.data));
        if (v.par) chk("vec_parity", 32'(frame[9]), 32'(v.exp_par));
        chk("vec_stop", 32'(frame[nb - 1]), 32'd1);
        chk("vec_done_cycle", 32'(done_cyc), 32'(v.len));
        chk("vec_extra_pop", 32'(pops), 32'd0);
    endtask

    initial begin
        bit got;
        int gaps, npops;
        int pc[2];

        vecs[0] = '{par: 1'b0, data: 8'hA5, exp_par: 1'b0, len: 40};
        vecs[1] = '{par: 1'b1, data: 8'hA5, exp_par: 1'b0, len: 44};
        vecs[2] = '{par: 1'b1, data: 8'h01, exp_par: 1'b1, len: 44};
        vecs[3] = '{par: 1'b1, data: 8'hFF, exp_par: 1'b0, len: 44};
        vecs[4] = '{par: 1'b0, data: 8'h3C, exp_par: 1'b0, len: 40};
        vecs[5] = '{par: 1'b1, data: 8'h80, exp_par: 1'b1, len: 44};

        // Reset held with a non-empty FIFO.
        ena0 = 1'b1; ena1 = 1'b1;
        q0.push_back(8'hC3);
        refresh();
        repeat (5) @(negedge clk);
        chk("rst_tx", 32'(tx0), 32'd1);
        chk("rst_rd_en", 32'(rd_en0), 32'd0);
        chk("rst_busy", 32'(busy0), 32'd0);
        @(posedge clk); #2 rst_n = 1'b1;
        @(negedge clk);
        chk("first_pop", 32'(rd_en0), 32'd1);
        wait_idle(200);

        // Table of single frames on both variants.
        foreach (vecs[i]) begin
            run_vec(vecs[i]);
            wait_idle(200);
        end

        // Three preloaded bytes stream back to back.
        @(posedge clk); #1;
        ena0 = 1'b0;
        q0.push_back(8'h00); q0.push_back(8'hFF); q0.push_back(8'h3C);
        refresh();
        @(posedge clk); #1 ena0 = 1'b1;
        wait_pop0(10, got);
        chk("b2b_first_pop", 32'(got), 32'd1);
        gaps = 0; npops = 0; pc[0] = 0; pc[1] = 0;
        for (int c = 1; c <= 120; c++) begin
            @(negedge clk);
            if (!busy0) gaps++;
            if (rd_en0) begin
                if (npops < 2) pc[npops] = c;
                npops++;
            end
        end
        chk("b2b_gaps", 32'(gaps), 32'd0);
        chk("b2b_pops", 32'(npops), 32'd2);
        chk("b2b_pop1_cycle", 32'(pc[0]), 32'd40);
        chk("b2b_pop2_cycle", 32'(pc[1]), 32'd80);
        wait_idle(200);

        // ena dropped mid-frame.
        @(posedge clk); #1;
        q0.push_back(8'h55); q0.push_back(8'h99);
        refresh();
        wait_pop0(10, got);
        chk("ena_pop", 32'(got), 32'd1);
        repeat (10) @(posedge clk);
        #1 ena0 = 1'b0;
        npops = 0; got = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (rd_en0) npops++;
            if (done0) begin
                got = 1'b1;
                break;
            end
        end
        chk("ena_frame_done", 32'(got), 32'd1);
        repeat (8) begin
            @(negedge clk);
            if (rd_en0) npops++;
        end
        chk("ena_no_pop", 32'(npops), 32'd0);
        @(posedge clk); #1 ena0 = 1'b1;
        @(negedge clk);
        chk("ena_resume_pop", 32'(rd_en0), 32'd1);
        wait_idle(200);

        // Reset in the middle of a frame.
        @(posedge clk); #1;
        q0.push_back(8'hA5); q0.push_back(8'h3E);
        refresh();
        wait_pop0(10, got);
        chk("mrst_pop", 32'(got), 32'd1);
        repeat (18) @(posedge clk);
        #1 chk("mrst_tx_low", 32'(tx0), 32'd0);
        #1 rst_n = 1'b0;
        #1;
        chk("mrst_tx_async", 32'(tx0), 32'd1);
        chk("mrst_busy_async", 32'(busy0), 32'd0);
        @(posedge clk); #2 rst_n = 1'b1;
        @(negedge clk);
        chk("mrst_next_pop", 32'(rd_en0), 32'd1);
        wait_idle(200);

        // Random traffic with ena toggling, checked by the model.
        for (int i = 0; i < 600; i++) begin
            @(posedge clk); #1;
            if ($urandom_range(0, 7) == 0) q0.push_back(8'($urandom));
            if ($urandom_range(0, 15) == 0) ena0 = ~ena0;
            refresh();
        end
        @(posedge clk); #1 ena0 = 1'b1;
        wait_idle(3000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fifo_uart_tx.md
Name: fifo_uart_tx

Overview:
- Downstream drain stage for tt_um_fifo_stevej: pops bytes from the FIFO read port and serializes them as asynchronous UART frames on one output pin.
- Frame format: 1 start bit, 8 data bits LSB first, optional even parity, 1 stop bit.
- Sits between the FIFO head and a uo_out bit inside the tt_um wrapper.
- The FIFO read port is first-word fall-through: head data is valid whenever the FIFO is not empty.

Parameters:
- CLKS_PER_BIT, 4, clk cycles per serial bit; must be >= 2.
- PARITY_EN, 0, 1 inserts an even-parity bit after data bit 7.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  reset; asynchronous, active-low.
- ena  input  1  design enable; gates starting new frames only.
- fifo_empty  input  1  FIFO empty flag.
- fifo_rd_data  input  8  FIFO head byte; valid when fifo_empty=0.
- fifo_rd_en  output  1  pop strobe; one-cycle pulse.
- tx  output  1  serial line; idle high.
- busy  output  1  high while a frame is in progress.
- frame_done  output  1  one-cycle pulse on the last cycle of the stop bit.

Behaviour:
- Reset (async assert, sync-safe deassert via flops):
  - state=IDLE; tx=1; fifo_rd_en=0; busy=0; frame_done=0.
  - bit and cycle counters = 0; shift register = 0.
- State machine: IDLE -> START -> DATA -> (PARITY if PARITY_EN) -> STOP -> IDLE or START.
- IDLE:
  - Each cycle with ena=1 and fifo_empty=0: fifo_rd_en=1 (combinational from registered state, one cycle).
  - Same edge: latch fifo_rd_data into the shift register, compute parity = ^data, go to START.
- Bit timing: each bit state holds for exactly CLKS_PER_BIT cycles. Cycle counter width is $clog2(CLKS_PER_BIT), counts 0..CLKS_PER_BIT-1.
- START: tx=0, busy=1.
- DATA:
  - tx = shift register bit 0; shift right at the end of each bit period.
  - 3-bit bit counter; leave after bit 7.
- PARITY: tx = latched parity; the bit is chosen so the total count of ones in data + parity is even.
- STOP: tx=1.
  - Last cycle of STOP: frame_done=1.
  - If ena=1 and fifo_empty=0 on that cycle: pop (fifo_rd_en=1), latch, go directly to START. Back-to-back frames have no idle gap.
  - Otherwise go to IDLE; busy falls on the next cycle.
- Latency:
  - Pop edge to start bit on tx: 1 cycle (tx low from the cycle after fifo_rd_en).
  - Frame length: (10 + PARITY_EN) * CLKS_PER_BIT cycles.
- Boundary cases:
  - ena drop mid-frame: the current frame completes; no further pops.
  - FIFO becomes empty mid-frame: no effect on the current frame.
  - fifo_rd_en never asserts while fifo_empty=1.
  - At most one pop per frame.
  - Reset mid-frame: tx returns high immediately; the popped byte is discarded; no frame_done.
  - fifo_rd_data is sampled only on the pop cycle; later changes are ignored.

Decomposition:
- Package fifo_uart_pkg holds:
  - state enum (IDLE, START, DATA, PARITY, STOP), 3-bit encoding;
  - constant DATA_BITS=8;
  - localparam function for counter width.
- One natural sub-module: uart_baud_tick. It holds the cycle counter and emits bit_end when the count reaches CLKS_PER_BIT-1; the FSM clears it with a restart input.
- Datapath and FSM stay in the top module.

Test Plan (CLKS_PER_BIT=4, PARITY_EN=0 unless noted):
1. Reset with FIFO non-empty -> tx=1, fifo_rd_en=0, busy=0 throughout reset.
   - After release, pop occurs on the first active cycle.
2. Single byte 0xA5 -> exactly one fifo_rd_en pulse, then 40 cycles on tx:
   - 4x0 start;
   - data 1,0,1,0,0,1,0,1 at 4 cycles each;
   - 4x1 stop.
   - frame_done pulses at cycle 40; busy low from cycle 41.
3. PARITY_EN=1:
   - byte 0xA5 -> parity bit 0, frame 44 cycles;
   - byte 0x01 -> parity bit 1.
4. FIFO preloaded with 0x00, 0xFF, 0x3C -> three pops, each in the last cycle of the previous stop bit.
   - 120 contiguous cycles with no idle gap; decoded bytes match in order.
5. ena deasserted at cycle 10 of the 0x55 frame:
   - the frame completes intact;
   - no pop while ena=0 despite FIFO non-empty;
   - the next pop occurs the cycle after ena returns to 1.
6. rst_n asserted at cycle 18 of a frame:
   - tx=1 asynchronously, before the next clk edge;
   - no frame_done;
   - after release, the next FIFO byte is transmitted cleanly.
